mc_control_fsm: RTL

Parametrised multicycle control unit for the 16-bit processor: sequences fetch, decode, execute, memory and write-back for every opcode and drives all datapath control strobes. It adds to the current controller:
- a memory-ready wait handshake;
- ADDI, BNE and HALT instructions;
- illegal-opcode trapping;
- a retired-instruction counter.

It sits between the datapath (opcode in, strobes out) and the memory port (mem_ready in).

---
 rtl/mc_ctrl_pkg.sv | 62 ++++++
 rtl/mc_ctrl_outdec.sv | 72 +++++++
 rtl/mc_control_fsm.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// datapath select values and the bundled strobe word.
package mc_ctrl_pkg;

    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_LW   = 3'd1;
    localparam logic [2:0] OP_SW   = 3'd2;
    localparam logic [2:0] OP_BEQ  = 3'd3;
    localparam logic [2:0] OP_J    = 3'd4;
    localparam logic [2:0] OP_ADDI = 3'd5;
    localparam logic [2:0] OP_BNE  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_REXE    = 4'd6,
        ST_RWB     = 4'd7,
        ST_BEQ     = 4'd8,
        ST_JMP     = 4'd9,
        ST_IEXE    = 4'd10,
        ST_IWB     = 4'd11,
        ST_BNE     = 4'd12,
        ST_HALT    = 4'd13,
        ST_ILLEGAL = 4'd14
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BOFF   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic       branch_ne;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore decode of controller state to datapath strobes; only the FETCH
// PC/IR writes depend on mem_ready, and reset forces everything idle.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    input  logic   reset_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o           = '0;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.pc_source = PCSRC_ALU;
        if (!reset_i) begin
            case (state_i)
                ST_FETCH: begin
                    ctrl_o.mem_read  = 1'b1;
                    ctrl_o.alu_src_b = SRCB_FOUR;
                    ctrl_o.ir_write  = mem_ready_i;
                    ctrl_o.pc_write  = mem_ready_i;
                end
                ST_DECODE: ctrl_o.alu_src_b = SRCB_BOFF;
                ST_MEMADR: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_IMM;
                end
                ST_MEMRD: begin
                    ctrl_o.mem_read = 1'b1;
                    ctrl_o.i_or_d   = 1'b1;
                end
                ST_MEMWB: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.mem_to_reg = 1'b1;
                end
                ST_MEMWR: begin
                    ctrl_o.mem_write = 1'b1;
                    ctrl_o.i_or_d    = 1'b1;
                end
                ST_REXE: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_op    = ALUOP_FUNCT;
                end
                ST_RWB: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.reg_dst   = 1'b1;
                end
                ST_IEXE: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_IMM;
                    ctrl_o.alu_op    = ALUOP_ADD;
                end
                ST_IWB: ctrl_o.reg_write = 1'b1;
                ST_BEQ, ST_BNE: begin
                    ctrl_o.alu_src_a     = 1'b1;
                    ctrl_o.alu_op        = ALUOP_SUB;
                    ctrl_o.pc_write_cond = 1'b1;
                    ctrl_o.pc_source     = PCSRC_ALUOUT;
                    ctrl_o.branch_ne     = (state_i == ST_BNE);
                end
                ST_JMP: begin
                    ctrl_o.pc_write  = 1'b1;
                    ctrl_o.pc_source = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle processor controller: state sequencing, retired-instruction
// counter and sticky HALT/ILLEGAL flags; strobes come from mc_ctrl_outdec.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned CNT_W       = 16,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                ALUSrcA,
    output logic                BranchNe,
    output logic [1:0]          ALUOp,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic                halted,
    output logic                illegal_op,
    output logic [3:0]          state_out,
    output logic [CNT_W-1:0]    retired
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               halted_q, halted_d;
    logic               illegal_q, illegal_d;
    logic               mem_rdy;
    logic               retire;
    ctrl_t              ctrl;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    function automatic logic op_is(input logic [OPCODE_W-1:0] op, input logic [2:0] code);
        return op == OPCODE_W'(code);
    endfunction

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH:  if (mem_rdy) state_d = ST_DECODE;
            ST_DECODE: begin
                if (op_is(opcode, OP_LW) || op_is(opcode, OP_SW)) state_d = ST_MEMADR;
                else if (op_is(opcode, OP_R))    state_d = ST_REXE;
                else if (op_is(opcode, OP_BEQ))  state_d = ST_BEQ;
                else if (op_is(opcode, OP_J))    state_d = ST_JMP;
                else if (op_is(opcode, OP_ADDI)) state_d = ST_IEXE;
                else if (op_is(opcode, OP_BNE))  state_d = ST_BNE;
                else if (op_is(opcode, OP_HALT)) begin
                    state_d = ST_HALT;
                    retire  = 1'b1;
                end
                else state_d = ST_ILLEGAL;
            end
            ST_MEMADR: state_d = op_is(opcode, OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (mem_rdy) state_d = ST_MEMWB;
            ST_MEMWR: begin
                if (mem_rdy) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_REXE:   state_d = ST_RWB;
            ST_IEXE:   state_d = ST_IWB;
            ST_MEMWB, ST_RWB, ST_IWB, ST_BEQ, ST_BNE, ST_JMP: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_HALT, ST_ILLEGAL: state_d = state_q;
            default:   state_d = ST_FETCH;
        endcase

        retired_d = retired_q;
        if (retire) retired_d = retired_q + CNT_W'(1);
        halted_d  = halted_q  | (state_d == ST_HALT);
        illegal_d = illegal_q | (state_d == ST_ILLEGAL);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    mc_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_rdy),
        .reset_i     (reset),
        .ctrl_o      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign BranchNe    = ctrl.branch_ne;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign halted      = halted_q & ~reset;
    assign illegal_op  = illegal_q & ~reset;
    assign state_out   = state_q;
    assign retired     = retired_q;

endmodule
